// File: rtl/ccc_pkg.sv
// Shared CCC definitions: cc_ctrl_h function codes and the CC bus sequencer states.
package ccc_pkg;

  localparam logic [3:0] CC_NOP     = 4'h1;
  localparam logic [3:0] CC_ATCR_RD = 4'h2;
  localparam logic [3:0] CC_PSL_RD  = 4'h3;
  localparam logic [3:0] CC_CC_WR   = 4'h4;
  localparam logic [3:0] CC_SETV    = 4'h5;
  localparam logic [3:0] CC_PSL_WR  = 4'h9;
  localparam logic [3:0] CC_OP1     = 4'hA;
  localparam logic [3:0] CC_OP2     = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CON,
    ST_TURN,
    ST_TRAP_WAIT,
    ST_ATCR_RD,
    ST_ATCR_CAP
  } seq_state_t;

  // Codes that only the console path may place on the bus.
  function automatic logic cc_is_psl(input logic [3:0] code);
    return (code == CC_PSL_RD) || (code == CC_PSL_WR);
  endfunction

endpackage

// File: rtl/ccc_cc_sequencer_if.sv
// Signal bundle between the CC sequencer and its requesters, the CCC and the microsequencer.
interface ccc_cc_sequencer_if;
  logic       mc_valid_h;
  logic [3:0] mc_cc_ctrl_h;
  logic       mc_stall_h;
  logic       con_req_h;
  logic       con_wr_h;
  logic       con_gnt_h;
  logic [3:0] cc_ctrl_h;
  logic       arith_trap_l;
  logic [3:0] wbus_h;
  logic       trap_req_h;
  logic       trap_ack_h;
  logic [3:0] trap_code_h;
  logic       trap_vld_h;

  modport master (
    input  mc_valid_h, mc_cc_ctrl_h, con_req_h, con_wr_h, arith_trap_l, wbus_h, trap_ack_h,
    output mc_stall_h, con_gnt_h, cc_ctrl_h, trap_req_h, trap_code_h, trap_vld_h
  );

  modport slave (
    output mc_valid_h, mc_cc_ctrl_h, con_req_h, con_wr_h, arith_trap_l, wbus_h, trap_ack_h,
    input  mc_stall_h, con_gnt_h, cc_ctrl_h, trap_req_h, trap_code_h, trap_vld_h
  );
endinterface

// File: rtl/ccc_starve_ctr.sv
// Saturating count of enabled cycles a pending console request has been refused.
module ccc_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic b_clk_l,
  input  logic reset_h,
  input  logic en_h,
  input  logic inc_h,
  input  logic clr_h,
  output logic sat_h
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] count_q;

  always_ff @(posedge b_clk_l or posedge reset_h) begin
    if (reset_h) begin
      count_q <= '0;
    end else if (en_h) begin
      if (clr_h) begin
        count_q <= '0;
      end else if (inc_h && !sat_h) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

  assign sat_h = (count_q == CNT_MAX);

endmodule

// File: rtl/ccc_cc_sequencer.sv
// Sequences the CCC cc_ctrl_h bus: arbitrates microcode against console PSL access
// and runs the arithmetic-trap handshake with ATCR read and capture.
//
// state        | meaning
// ST_IDLE      | arbitrate: trap > console (forced or uncontested) > microcode > NOP
// ST_CON       | console PSL code on cc_ctrl_h, con_gnt_h high
// ST_TURN      | NOP for WBUS turnaround after console access
// ST_TRAP_WAIT | NOP, trap_req_h high until trap_ack_h
// ST_ATCR_RD   | ATCR read code on cc_ctrl_h
// ST_ATCR_CAP  | capture WBUS into trap_code_h, clear trap pending
module ccc_cc_sequencer
  import ccc_pkg::*;
#(
  parameter int unsigned STARVE_MAX   = 4,
  parameter logic [3:0]  NOP_CODE     = CC_NOP,
  parameter logic [3:0]  ATCR_RD_CODE = CC_ATCR_RD,
  parameter logic [3:0]  PSL_RD_CODE  = CC_PSL_RD,
  parameter logic [3:0]  PSL_WR_CODE  = CC_PSL_WR
) (
  input logic                b_clk_l,
  input logic                reset_h,
  input logic                d_clk_en_h,
  ccc_cc_sequencer_if.master bus
);

  seq_state_t state_q, state_nxt;
  logic       trap_pend_q, trap_pend_nxt;
  logic [3:0] cc_nxt;
  logic       gnt_nxt, treq_nxt, tvld_nxt, cap_en;
  logic       starve_sat, con_sel, mc_sel;

  ccc_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .b_clk_l (b_clk_l),
    .reset_h (reset_h),
    .en_h    (d_clk_en_h),
    .inc_h   (bus.con_req_h & ~con_sel),
    .clr_h   (con_sel),
    .sat_h   (starve_sat)
  );

  assign con_sel = (state_q == ST_IDLE) & ~trap_pend_q & bus.con_req_h
                 & (starve_sat | ~bus.mc_valid_h);
  assign mc_sel  = (state_q == ST_IDLE) & ~trap_pend_q & ~con_sel & bus.mc_valid_h;
  assign bus.mc_stall_h = bus.mc_valid_h & ~mc_sel;

  always_comb begin
    state_nxt     = state_q;
    cc_nxt        = NOP_CODE;
    gnt_nxt       = 1'b0;
    treq_nxt      = 1'b0;
    tvld_nxt      = 1'b0;
    cap_en        = 1'b0;
    trap_pend_nxt = trap_pend_q | ~bus.arith_trap_l;
    case (state_q)
      ST_IDLE: begin
        if (trap_pend_q) begin
          state_nxt = ST_TRAP_WAIT;
          treq_nxt  = 1'b1;
        end else if (con_sel) begin
          state_nxt = ST_CON;
          cc_nxt    = bus.con_wr_h ? PSL_WR_CODE : PSL_RD_CODE;
          gnt_nxt   = 1'b1;
        end else if (mc_sel) begin
          cc_nxt = bus.mc_cc_ctrl_h;
        end
      end
      ST_CON:  state_nxt = ST_TURN;
      ST_TURN: state_nxt = ST_IDLE;
      ST_TRAP_WAIT: begin
        if (bus.trap_ack_h) begin
          state_nxt = ST_ATCR_RD;
          cc_nxt    = ATCR_RD_CODE;
        end else begin
          treq_nxt = 1'b1;
        end
      end
      ST_ATCR_RD: state_nxt = ST_ATCR_CAP;
      ST_ATCR_CAP: begin
        // WBUS carries the ATCR value in the cycle after the read code was driven
        cap_en        = 1'b1;
        tvld_nxt      = 1'b1;
        trap_pend_nxt = 1'b0;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge b_clk_l or posedge reset_h) begin
    if (reset_h) begin
      state_q         <= ST_IDLE;
      trap_pend_q     <= 1'b0;
      bus.cc_ctrl_h   <= NOP_CODE;
      bus.con_gnt_h   <= 1'b0;
      bus.trap_req_h  <= 1'b0;
      bus.trap_vld_h  <= 1'b0;
      bus.trap_code_h <= '0;
    end else if (d_clk_en_h) begin
      state_q        <= state_nxt;
      trap_pend_q    <= trap_pend_nxt;
      bus.cc_ctrl_h  <= cc_nxt;
      bus.con_gnt_h  <= gnt_nxt;
      bus.trap_req_h <= treq_nxt;
      bus.trap_vld_h <= tvld_nxt;
      if (cap_en) bus.trap_code_h <= bus.wbus_h;
    end
  end

endmodule
